pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline control and performance-monitor unit for the N-stage MIPS datapath. It centralises the stall, bubble, flush and freeze decisions that feed every pipeline register. It adds a memory-wait handshake and a syscall-driven RUN/PAUSE/HALT state machine with a resume input, plus a bank of saturating statistics counters read through one select port. It sits beside the datapath top level and replaces the ad-hoc go/bubble/clear wiring.

## Interface
- STAGES, 5: pipeline stage count; legal values are 3 or more. There are STAGES-1 pipeline registers, where reg k sits between stage k and stage k+1.
- RESOLVE, 2: stage that resolves branches and jumps; legal range is 1..STAGES-2.
- CNT_W, 32: width of each statistics counter.

- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- load_use  in  1  load-use hazard detected in stage 1 (ID)
- redirect  in  1  control transfer resolved in RESOLVE; PC redirected
- mem_req  in  1  MEM stage is issuing a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- syscall_wb  in  1  a syscall is in WB
- syscall_code  in  32  $v0 value accompanying the syscall
- resume  in  1  single-cycle pulse that leaves PAUSE
- exe_valid  in  1  RESOLVE stage holds a real instruction
- exe_uncond  in  1  the instruction is an unconditional jump
- exe_cond  in  1  the instruction is a conditional branch
- exe_taken  in  1  the conditional branch is taken
- cnt_sel  in  3  counter readout select
- pc_en  out  1  PC register enable
- stage_en  out  STAGES-1  per-register enable
- stage_flush  out  STAGES-1  per-register synchronous clear; overrides stage_en
- halted  out  1  state is HALT
- paused  out  1  state is PAUSE
- cnt_out  out  CNT_W  selected counter value

## Operation
- State machine states: RUN=0, PAUSE=1, HALT=2.
- RUN to HALT: syscall_wb=1 with syscall_code=0x0000000A.
- RUN to PAUSE: syscall_wb=1 with syscall_code=0x00000032.
- PAUSE to RUN: resume=1.
- HALT is left only by rst.
- Other syscall codes have no effect.
- While in PAUSE, syscall_wb is ignored.
- freeze = (RUN and halt/pause trigger this cycle) or (PAUSE and !resume) or HALT. A frozen cycle gives pc_en=0, all stage_en=0 and no flush.
- wait = mem_req & !mem_ready. A wait cycle freezes the whole pipeline exactly as freeze does; redirect and load_use are held, not acted upon.
- Redirect cycle (not frozen, no wait): pc_en=1, all stage_en=1, stage_flush[k]=1 for k<RESOLVE.
- Load-use cycle (no redirect, not frozen, no wait): pc_en=0, stage_en[0]=0, stage_flush[1]=1 (bubble), remaining registers enabled.
- Priority: rst > freeze > wait > redirect > load_use > normal. Redirect wins over load_use because the stalled instruction is being flushed anyway.
- Normal cycle: pc_en=1, all stage_en=1, no flush.
- advance = !rst & !freeze & !wait.
- Counters saturate at all-ones. cnt_sel selects:
  - 0 total: RUN and advance
  - 1 uncond: advance & exe_valid & exe_uncond
  - 2 cond: advance & exe_valid & exe_cond
  - 3 cond_taken: the cond condition & exe_taken
  - 4 stall: RUN & !freeze & (wait | (load_use & !redirect))
  - 5 flush: advance & redirect
  - 6 and 7 read 0
- cnt_out is a combinational mux of the registered counters.

## Timing
- Reset: while rst=1, pc_en=0, stage_en all 0, stage_flush all 1. On the next edge state goes to RUN and counters clear. After reset, halted=0, paused=0, cnt_out=0.
- Control outputs are combinational from the inputs and the current state; they take effect at the same edge. There is zero-cycle latency from a hazard to the freeze or flush.
- halted and paused are registered and assert one cycle after the trigger cycle. The trigger cycle itself is already frozen, so the syscall stays in WB.
- Resume cycle: enables go high that cycle, the syscall leaves WB at the edge, and the state is RUN on the next cycle.
- A syscall halt or pause with wait=1 in the same cycle: the state transition still occurs.
- rst asserted mid-wait or mid-PAUSE: reset wins, with no residual state.
- Counter at all-ones plus an increment condition: the counter holds at all-ones.

## Configuration
- PIPE_CTRL_PERF_EN defined: the counter bank and cnt_out mux are built.
- Undefined: no counter registers exist and cnt_out is tied to 0. Control behaviour is identical.

## Test plan
- Reset, then 10 normal cycles: pc_en=1, stage_en=4'b1111, flush=0, cnt_sel=0 gives 10.
- load_use=1 for one cycle: pc_en=0, stage_en=4'b1110, stage_flush=4'b0010; cnt_sel=4 gives 1. load_use and redirect together: stage_flush=4'b0011, pc_en=1.
- mem_req=1, mem_ready=0 for 3 cycles alongside redirect=1: all enables 0 and no flush for 3 cycles. On the 4th cycle, with mem_ready=1, a single flush of 4'b0011; stall=3, flush=1.
- syscall_wb=1 with code 0x32: freeze that cycle, paused=1 next cycle. Hold 5 cycles; total is unchanged. Pulse resume: enables high that cycle, then paused=0.
- syscall_wb=1 with code 0xA: halted=1 forever while resume is toggled. rst clears it, and counters read 0.
- With PIPE_CTRL_PERF_EN and CNT_W=4: run 20 cycles, and cnt_sel=0 gives 4'hF.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline stall/bubble/flush/freeze control with syscall RUN/PAUSE/HALT state machine.
// Define PIPE_CTRL_PERF_EN to build the saturating statistics counter bank.
module pipe_ctrl #(
  parameter int unsigned STAGES  = 5,
  parameter int unsigned RESOLVE = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_use,
  input  logic                redirect,
  input  logic                mem_req,
  input  logic                mem_ready,
  input  logic                syscall_wb,
  input  logic [31:0]         syscall_code,
  input  logic                resume,
  input  logic                exe_valid,
  input  logic                exe_uncond,
  input  logic                exe_cond,
  input  logic                exe_taken,
  input  logic [2:0]          cnt_sel,
  output logic                pc_en,
  output logic [STAGES-2:0]   stage_en,
  output logic [STAGES-2:0]   stage_flush,
  output logic                halted,
  output logic                paused,
  output logic [CNT_W-1:0]    cnt_out
);

  localparam int unsigned NREG = STAGES - 1;
  localparam logic [31:0] CODE_HALT  = 32'h0000_000A;
  localparam logic [31:0] CODE_PAUSE = 32'h0000_0032;
  // Registers upstream of the resolving stage hold wrong-path instructions.
  localparam logic [NREG-1:0] REDIRECT_MASK = NREG'((64'd1 << RESOLVE) - 64'd1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   halt_trig, pause_trig, freeze, mem_wait, advance;

  assign halt_trig  = (state == ST_RUN) && syscall_wb && (syscall_code == CODE_HALT);
  assign pause_trig = (state == ST_RUN) && syscall_wb && (syscall_code == CODE_PAUSE);
  assign freeze     = halt_trig || pause_trig || (state == ST_HALT) ||
                      ((state == ST_PAUSE) && !resume);
  assign mem_wait   = mem_req && !mem_ready;
  assign advance    = !rst && !freeze && !mem_wait;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (halt_trig)       state_nxt = ST_HALT;
        else if (pause_trig) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: if (resume) state_nxt = ST_RUN;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Priority: reset > freeze/wait > redirect > load-use bubble > normal.
  always_comb begin
    pc_en       = 1'b1;
    stage_en    = '1;
    stage_flush = '0;
    if (rst) begin
      pc_en       = 1'b0;
      stage_en    = '0;
      stage_flush = '1;
    end else if (freeze || mem_wait) begin
      pc_en    = 1'b0;
      stage_en = '0;
    end else if (redirect) begin
      stage_flush = REDIRECT_MASK;
    end else if (load_use) begin
      pc_en          = 1'b0;
      stage_en[0]    = 1'b0;
      stage_flush[1] = 1'b1;
    end
  end

  assign halted = (state == ST_HALT);
  assign paused = (state == ST_PAUSE);

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] cnt_q [6];
  logic [5:0]       cnt_inc;

  assign cnt_inc[0] = (state == ST_RUN) && advance;
  assign cnt_inc[1] = advance && exe_valid && exe_uncond;
  assign cnt_inc[2] = advance && exe_valid && exe_cond;
  assign cnt_inc[3] = advance && exe_valid && exe_cond && exe_taken;
  assign cnt_inc[4] = (state == ST_RUN) && !freeze && (mem_wait || (load_use && !redirect));
  assign cnt_inc[5] = advance && redirect;

  // Saturating counters: hold at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (rst)
        cnt_q[i] <= '0;
      else if (cnt_inc[i] && (cnt_q[i] != {CNT_W{1'b1}}))
        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  always_comb begin
    cnt_out = '0;
    case (cnt_sel)
      3'd0:    cnt_out = cnt_q[0];
      3'd1:    cnt_out = cnt_q[1];
      3'd2:    cnt_out = cnt_q[2];
      3'd3:    cnt_out = cnt_q[3];
      3'd4:    cnt_out = cnt_q[4];
      3'd5:    cnt_out = cnt_q[5];
      default: cnt_out = '0;
    endcase
  end
`else
  logic unused_perf;
  assign unused_perf = ^{exe_valid, exe_uncond, exe_cond, exe_taken, cnt_sel, advance};
  assign cnt_out     = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares. A second CNT_W=4 instance checks saturation.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, load_use, redirect, mem_req, mem_ready, syscall_wb, resume;
  logic [31:0] syscall_code;
  logic        exe_valid, exe_uncond, exe_cond, exe_taken;
  logic [2:0]  cnt_sel;
  logic        pc_en, halted, paused;
  logic [3:0]  stage_en, stage_flush;
  logic [31:0] cnt_out;
  logic        pc_en_s, halted_s, paused_s;
  logic [3:0]  stage_en_s, stage_flush_s;
  logic [3:0]  cnt_out_s;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(5), .RESOLVE(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .load_use(load_use), .redirect(redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .syscall_wb(syscall_wb),
    .syscall_code(syscall_code), .resume(resume), .exe_valid(exe_valid),
    .exe_uncond(exe_uncond), .exe_cond(exe_cond), .exe_taken(exe_taken),
    .cnt_sel(cnt_sel), .pc_en(pc_en), .stage_en(stage_en),
    .stage_flush(stage_flush), .halted(halted), .paused(paused), .cnt_out(cnt_out)
  );

  pipe_ctrl #(.STAGES(5), .RESOLVE(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .load_use(load_use), .redirect(redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .syscall_wb(syscall_wb),
    .syscall_code(syscall_code), .resume(resume), .exe_valid(exe_valid),
    .exe_uncond(exe_uncond), .exe_cond(exe_cond), .exe_taken(exe_taken),
    .cnt_sel(cnt_sel), .pc_en(pc_en_s), .stage_en(stage_en_s),
    .stage_flush(stage_flush_s), .halted(halted_s), .paused(paused_s), .cnt_out(cnt_out_s)
  );

  typedef struct packed {
    logic [15:0] id;
    logic        pc;
    logic [3:0]  en;
    logic [3:0]  fl;
    logic        chk_st;
    logic        h;
    logic        p;
    logic        chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc_id = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, id, act, exp);
    end
  endtask

  // Monitor: every pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] ec, es;
      e = sb.pop_front();
      chk("pc_en", int'(e.id), 32'(pc_en), 32'(e.pc));
      chk("stage_en", int'(e.id), 32'(stage_en), 32'(e.en));
      chk("stage_flush", int'(e.id), 32'(stage_flush), 32'(e.fl));
      if (e.chk_st) begin
        chk("halted", int'(e.id), 32'(halted), 32'(e.h));
        chk("paused", int'(e.id), 32'(paused), 32'(e.p));
      end
      if (e.chk_cnt) begin
`ifdef PIPE_CTRL_PERF_EN
        ec = e.cnt;
        es = (e.cnt > 32'd15) ? 32'd15 : e.cnt;
`else
        ec = 32'd0;
        es = 32'd0;
`endif
        chk("cnt_out", int'(e.id), cnt_out, ec);
        chk("cnt_out_sat4", int'(e.id), 32'(cnt_out_s), es);
      end
    end
  end

  task automatic clear_inputs();
    rst = 1'b0; load_use = 1'b0; redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    syscall_wb = 1'b0; syscall_code = 32'd0; resume = 1'b0;
    exe_valid = 1'b0; exe_uncond = 1'b0; exe_cond = 1'b0; exe_taken = 1'b0;
    cnt_sel = 3'd0;
  endtask

  // Push expectation for the inputs currently applied, then advance one clock.
  task automatic cyc(input logic pc, input logic [3:0] en, input logic [3:0] fl,
                     input logic cs, input logic h, input logic p,
                     input logic cc, input logic [31:0] cv);
    exp_t e;
    e.id = 16'(cyc_id); e.pc = pc; e.en = en; e.fl = fl;
    e.chk_st = cs; e.h = h; e.p = p; e.chk_cnt = cc; e.cnt = cv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc_id++;
    clear_inputs();
  endtask

  task automatic norm(input logic [2:0] sel, input logic [31:0] cv);
    cnt_sel = sel;
    cyc(1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, cv);
  endtask

  initial begin
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int k = 1; k <= 10; k++) norm(3'd0, 32'(k - 1));
    // Load-use bubble, then stall count
    load_use = 1'b1;
    cyc(1'b0, 4'hE, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 32'd10);
    norm(3'd4, 32'd1);
    // Redirect beats load-use
    load_use = 1'b1; redirect = 1'b1; cnt_sel = 3'd5;
    cyc(1'b1, 4'hF, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    // Memory wait holds a pending redirect
    for (int i = 0; i < 3; i++) begin
      mem_req = 1'b1; redirect = 1'b1; cnt_sel = 3'd5;
      cyc(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1);
    end
    mem_req = 1'b1; mem_ready = 1'b1; redirect = 1'b1; cnt_sel = 3'd4;
    cyc(1'b1, 4'hF, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 32'd4);
    // Branch/jump statistics
    exe_valid = 1'b1; exe_cond = 1'b1; exe_taken = 1'b1;
    norm(3'd5, 32'd2);
    exe_valid = 1'b1; exe_uncond = 1'b1;
    norm(3'd0, 32'd15);
    exe_valid = 1'b1; exe_cond = 1'b1;
    norm(3'd1, 32'd1);
    exe_cond = 1'b1;
    norm(3'd2, 32'd2);
    norm(3'd3, 32'd1);
    norm(3'd6, 32'd0);
    // Pause trigger freezes even with redirect and load-use present
    syscall_wb = 1'b1; syscall_code = 32'h32; load_use = 1'b1; redirect = 1'b1;
    cyc(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd20);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin syscall_wb = 1'b1; syscall_code = 32'hA; end
      cyc(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd20);
    end
    resume = 1'b1; cnt_sel = 3'd4;
    cyc(1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd4);
    norm(3'd0, 32'd20);
    // Halt during a memory wait still transitions
    syscall_wb = 1'b1; syscall_code = 32'hA; mem_req = 1'b1;
    cyc(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd21);
    for (int i = 0; i < 4; i++) begin
      resume = (i % 2 == 0); cnt_sel = 3'd4;
      cyc(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd4);
    end
    rst = 1'b1; resume = 1'b1;
    cyc(1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    norm(3'd0, 32'd0);
    // Unrecognised syscall code has no effect
    syscall_wb = 1'b1; syscall_code = 32'h1;
    norm(3'd4, 32'd0);
    // Reset mid-PAUSE
    syscall_wb = 1'b1; syscall_code = 32'h32; mem_req = 1'b1;
    cyc(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2);
    mem_req = 1'b1; load_use = 1'b1;
    cyc(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd2);
    rst = 1'b1;
    cyc(1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 32'd2);
    // Saturation on the 4-bit instance
    for (int k = 0; k <= 20; k++) norm(3'd0, 32'(k));
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      nchk++;
      nerr++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
